// File: rtl/restoring_divider_n_if.sv
// Handshake/operand bundle for restoring_divider_n.
// Optional feature macro: RESTORING_DIV_SIGNED_EN adds signed_mode.
// Ports (master = requester, slave = divider):
//   start, dividend, divisor, [signed_mode]        master -> slave
//   ready, done, quotient, remainder, div_by_zero  slave  -> master
interface restoring_divider_n_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef RESTORING_DIV_SIGNED_EN
  logic             signed_mode;
`endif
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef RESTORING_DIV_SIGNED_EN
  modport master (output start, dividend, divisor, signed_mode,
                  input  ready, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor, signed_mode,
                  output ready, done, quotient, remainder, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  ready, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output ready, done, quotient, remainder, div_by_zero);
`endif
endinterface

// File: rtl/restoring_divider_n.sv
// Multi-cycle restoring divider: one quotient bit per clock, with
// divide-by-zero detection. Optional macro RESTORING_DIV_SIGNED_EN adds
// truncating two's-complement division selected by bus.signed_mode.
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   bus     restoring_divider_n_if.slave (start/operands in; ready, done,
//           quotient, remainder, div_by_zero out, all registered)
module restoring_divider_n #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  resetn,
  restoring_divider_n_if.slave bus
);
  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             ready_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             dbz_reg;
`ifdef RESTORING_DIV_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  logic [AW-1:0]    a_shift;
  logic [AW-1:0]    trial;
  logic [AW-1:0]    a_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  // One restoring iteration; the restore is just selecting a_shift over trial.
  // The cast drops a[WIDTH], which is always zero after any iteration.
  always_comb begin
    a_shift = AW'({a, q[WIDTH-1]});
    trial   = a_shift - {1'b0, d};
    a_next  = trial;
    q_next  = {q[WIDTH-2:0], 1'b1};
    if (trial[WIDTH]) begin
      a_next = a_shift;
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

  // Operand magnitudes and final sign fix-up.
  always_comb begin
    dividend_mag = bus.dividend;
    divisor_mag  = bus.divisor;
    q_final      = q_next;
    r_final      = a_next[WIDTH-1:0];
`ifdef RESTORING_DIV_SIGNED_EN
    if (bus.signed_mode && bus.dividend[WIDTH-1]) dividend_mag = ~bus.dividend + WIDTH'(1);
    if (bus.signed_mode && bus.divisor[WIDTH-1])  divisor_mag  = ~bus.divisor + WIDTH'(1);
    if (neg_q) q_final = ~q_next + WIDTH'(1);
    if (neg_r) r_final = ~a_next[WIDTH-1:0] + WIDTH'(1);
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      a             <= '0;
      q             <= '0;
      d             <= '0;
      ready_reg     <= 1'b1;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
`ifdef RESTORING_DIV_SIGNED_EN
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ready_reg <= 1'b0;
            cnt       <= '0;
            a         <= '0;
            q         <= dividend_mag;
            d         <= divisor_mag;
`ifdef RESTORING_DIV_SIGNED_EN
            neg_q     <= bus.signed_mode && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r     <= bus.signed_mode && bus.dividend[WIDTH-1];
`endif
            if (bus.divisor == '0) begin
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend;
              dbz_reg       <= 1'b1;
              state         <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          a   <= a_next;
          q   <= q_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            cnt           <= '0;
            quotient_reg  <= q_final;
            remainder_reg <= r_final;
            dbz_reg       <= 1'b0;
            done_reg      <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // Divide-by-zero arrives with done low, so it pulses done one edge later.
          if (!done_reg) begin
            done_reg <= 1'b1;
          end else begin
            done_reg  <= 1'b0;
            ready_reg <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready       = ready_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_restoring_divider_n.sv
// Directed bench for restoring_divider_n at WIDTH=8, plus a start-held-high
// stream checked against integer / and %.
module tb_restoring_divider_n;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  restoring_divider_n_if #(.WIDTH(WIDTH)) bus ();

  restoring_divider_n #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE and check latency, pulse width and results.
  task automatic do_op(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                       input logic sm, input logic [7:0] eq, input logic [7:0] er,
                       input logic ez);
    int n;
`ifdef RESTORING_DIV_SIGNED_EN
    bus.signed_mode = sm;
`else
    if (sm) $display("note: signed step %s run in unsigned build", tag);
`endif
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), ez ? 32'd1 : 32'(WIDTH));
    chk({tag, "_quot"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_rem"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
    tick();
    chk({tag, "_done_1wide"}, 32'(bus.done), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
    chk({tag, "_quot_held"}, 32'(bus.quotient), 32'(eq));
  endtask

  initial begin
    int n;
    int seen_done;
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] nd;
    logic [7:0] nv;
    errors = 0;
    checks = 0;
    resetn       = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef RESTORING_DIV_SIGNED_EN
    bus.signed_mode = 1'b0;
`endif
    tick();
    tick();
    resetn = 1'b1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quot", 32'(bus.quotient), 32'd0);
    chk("rst_rem", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);

    do_op("100_7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0);
    do_op("5_0", 8'd5, 8'd0, 1'b0, 8'hFF, 8'd5, 1'b1);
    do_op("255_1", 8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0);
    do_op("255_255", 8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0);

    // start reissued with junk operands throughout CALC must be ignored.
    bus.dividend = 8'd3;
    bus.divisor  = 8'd9;
    bus.start    = 1'b1;
    tick();
    n = 0;
    while (!bus.done && n < 40) begin
      bus.start    = 1'b1;
      bus.dividend = 8'($urandom);
      bus.divisor  = 8'($urandom);
      tick();
      n++;
    end
    bus.start = 1'b0;
    chk("ign_latency", 32'(n), 32'(WIDTH));
    chk("ign_quot", 32'(bus.quotient), 32'd0);
    chk("ign_rem", 32'(bus.remainder), 32'd3);
    tick();
    chk("ign_ready", 32'(bus.ready), 32'd1);

    // Reset in the middle of CALC drops the operation without a done pulse.
    do_op("pre_rst", 8'd77, 8'd10, 1'b0, 8'd7, 8'd7, 1'b0);
    bus.dividend = 8'd200;
    bus.divisor  = 8'd13;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_quot", 32'(bus.quotient), 32'd0);
    chk("mid_rst_rem", 32'(bus.remainder), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) seen_done = 1;
    end
    chk("mid_rst_no_done", 32'(seen_done), 32'd0);
    do_op("200_13", 8'd200, 8'd13, 1'b0, 8'd15, 8'd5, 1'b0);

    // start held high: one result every WIDTH+2 cycles.
    dd = 8'($urandom);
    dv = 8'($urandom_range(1, 255));
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      n = 0;
      while (!bus.done && n < 40) begin
        tick();
        n++;
      end
      chk("strm_latency", 32'(n), 32'(WIDTH));
      chk("strm_quot", 32'(bus.quotient), 32'(dd / dv));
      chk("strm_rem", 32'(bus.remainder), 32'(dd % dv));
      nd = 8'($urandom);
      nv = 8'($urandom_range(1, 255));
      bus.dividend = nd;
      bus.divisor  = nv;
      tick();
      chk("strm_ready", 32'(bus.ready), 32'd1);
      tick();
      dd = nd;
      dv = nv;
    end
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    chk("strm_last_quot", 32'(bus.quotient), 32'(dd / dv));
    chk("strm_last_rem", 32'(bus.remainder), 32'(dd % dv));
    tick();

`ifdef RESTORING_DIV_SIGNED_EN
    do_op("s_m7_2", 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0);
    do_op("s_7_m2", 8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0);
    do_op("s_m128_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
    do_op("s_m7_m2", 8'hF9, 8'hFE, 1'b1, 8'h03, 8'hFF, 1'b0);
    do_op("s_m5_0", 8'hFB, 8'h00, 1'b1, 8'hFF, 8'hFB, 1'b1);
    do_op("s_off_f9_2", 8'hF9, 8'h02, 1'b0, 8'h7C, 8'h01, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
